wallace_cpa_pipe: RTL and testbench
===================================

Name: wallace_cpa_pipe

Overview:
- Final carry-propagate stage downstream of a row of wallace_1_8 column compressors.
- Column i's compressor produces S[i] (weight 2^i) and C[i] (weight 2^(i+1)). This block registers the two vectors and forms SUM = S + (C << 1) modulo 2^WIDTH.
- It is a 2-stage pipeline (low half, then high half) with valid/ready handshakes on both sides, so the multiplier datapath can stall.

Parameters:
- WIDTH, 32, number of compressor columns = product width; must be even and >= 4.
- HALF, WIDTH/2, split point between pipeline stages; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_s/in_c hold a valid column set
- in_ready  output  1  block accepts input this cycle
- in_s  input  WIDTH  per-column S outputs; bit i = column i
- in_c  input  WIDTH  per-column C outputs; bit i = column i, weight 2^(i+1)
- out_valid  output  1  out_sum valid
- out_ready  input  1  downstream accepts out_sum
- out_sum  output  WIDTH  (in_s + (in_c << 1)) mod 2^WIDTH
- out_cout  output  1  1 when the true sum is >= 2^WIDTH

Behaviour:
- Reset (async assert, sync release): s1_valid=0, out_valid=0, out_sum=0, out_cout=0, and all stage-1 data registers are 0.
- While rst_n is low, in_ready=0.
- Operand alignment: A = in_s, B = {in_c[WIDTH-2:0], 1'b0}. in_c[WIDTH-1] goes only to the cout logic.
- Stage 1, on input transfer (in_valid & in_ready):
  - registers lo_sum = A[HALF-1:0] + B[HALF-1:0] (HALF bits) and lo_carry;
  - registers A[WIDTH-1:HALF], B[WIDTH-1:HALF] and c_msb = in_c[WIDTH-1];
  - sets s1_valid=1.
- Stage 2, on stage-1 advance:
  - out_sum = {A_hi + B_hi + lo_carry (HALF bits), lo_sum};
  - out_cout = carry out of the high add | c_msb;
  - sets out_valid=1.
- Handshake rules:
  - out_fire = out_valid & out_ready.
  - s2_free = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = rst_n & (!s1_valid | s2_free). This is combinational from registers and out_ready only; it never depends on in_valid.
- Stage-1 state:
  - s1_valid next = in_fire | (s1_valid & !s1_adv).
  - s1 data loads only on in_fire.
- Stage-2 state:
  - out_valid next = s1_adv | (out_valid & !out_ready).
  - out_sum/out_cout load only on s1_adv. They hold stable while out_valid & !out_ready.
- Latency: input accepted at edge k gives out_valid high after edge k+1 (2 registers). Throughput is 1 result/cycle with out_ready tied high.
- Backpressure: with out_ready low, one result is held at the output and one in stage 1; then in_ready=0. Nothing is dropped or duplicated.
- Simultaneous events: when full, out_fire, s1_adv and in_fire can all happen in the same cycle; all three move together.
- Wrap-around: the sum truncates to WIDTH bits. Overflow is reported only through out_cout.
- Reset mid-operation: all in-flight results are discarded. The first output after release comes from the first post-reset input.
- Data registers are not cleared on pop; only the valid bits gate them.

Decomposition:
- Shared package wallace_pkg:
  - WALLACE_PROD_W default (32) and HALF derivation;
  - handshake helper constant/function for the even-WIDTH check, raising an elaboration error if WIDTH is odd.
- One natural sub-module: wallace_cpa_half. Combinational HALF-bit adder with cin/cout, instantiated once per stage (cin=0 for the low stage).
- Everything else (pipeline registers, handshake) stays in wallace_cpa_pipe.

Test Plan:
- Basic, WIDTH=32: in_s=0x00000005, in_c=0x00000003, out_ready=1 -> out_sum=0x0000000B, out_cout=0, out_valid high exactly 2 cycles after acceptance.
- Cross-half carry: in_s=0x0000FFFF, in_c=0x00000001 -> out_sum=0x00010001, out_cout=0.
- Overflow and MSB: in_s=0xFFFFFFFF, in_c=0x00000001 -> out_sum=0x00000001, out_cout=1. Then in_s=0, in_c=0x80000000 -> out_sum=0, out_cout=1.
- Backpressure: out_ready=0, stream 3 inputs -> first two accepted, then in_ready=0, out_sum frozen on result 1. Raise out_ready -> results 1,2,3 emerge in order, none lost or duplicated.
- Throughput: 100 random in_s/in_c back-to-back with out_ready=1 -> in_ready always 1 and 100 outputs on consecutive cycles, matching a reference model (s + 2c) mod 2^32 plus cout.
- Reset mid-flight: two results in flight, pulse rst_n low asynchronously mid-cycle -> out_valid=0, out_sum=0 immediately; after release, the first output equals the first post-reset input's sum.

Source files
------------

// File: rtl/wallace_pkg.sv
// wallace_pkg: shared widths and parameter checks for the wallace multiplier datapath
package wallace_pkg;

   localparam int WALLACE_PROD_W = 32;

   function automatic int half_of(input int w);
      return w / 2;
   endfunction

   function automatic bit width_ok(input int w);
      return (w % 2 == 0) && (w >= 4);
   endfunction

endpackage

// File: rtl/wallace_cpa_half.sv
// wallace_cpa_half: combinational W-bit ripple adder with carry in and carry out
module wallace_cpa_half #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/wallace_cpa_pipe.sv
// wallace_cpa_pipe: two-stage pipelined carry-propagate adder merging compressor S/C rows
module wallace_cpa_pipe
   import wallace_pkg::*;
#(
   parameter int WIDTH = WALLACE_PROD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_s,
   input  logic [WIDTH-1:0] in_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int HALF = half_of(WIDTH);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("wallace_cpa_pipe: WIDTH must be even and >= 4");
      end
   endgenerate

   logic [WIDTH-1:0] b_in;
   logic [HALF-1:0]  lo_sum_d, lo_sum, a_hi, b_hi, hi_sum;
   logic             lo_carry_d, lo_carry, c_msb, hi_cout;
   logic             s1_valid, in_fire, s2_free, s1_adv;

   // C[i] carries weight 2^(i+1); its top bit falls outside the sum and only feeds cout
   assign b_in     = {in_c[WIDTH-2:0], 1'b0};
   assign s2_free  = !out_valid | out_ready;
   assign s1_adv   = s1_valid & s2_free;
   assign in_ready = rst_n & (!s1_valid | s2_free);
   assign in_fire  = in_valid & in_ready;

   wallace_cpa_half #(.W(HALF)) u_lo (
      .a    (in_s[HALF-1:0]),
      .b    (b_in[HALF-1:0]),
      .cin  (1'b0),
      .sum  (lo_sum_d),
      .cout (lo_carry_d)
   );

   wallace_cpa_half #(.W(HALF)) u_hi (
      .a    (a_hi),
      .b    (b_hi),
      .cin  (lo_carry),
      .sum  (hi_sum),
      .cout (hi_cout)
   );

   // Stage 1: low-half sum plus the raw high-half operands, loaded on input transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         lo_sum   <= '0;
         lo_carry <= 1'b0;
         a_hi     <= '0;
         b_hi     <= '0;
         c_msb    <= 1'b0;
      end else begin
         s1_valid <= in_fire | (s1_valid & !s1_adv);
         if (in_fire) begin
            lo_sum   <= lo_sum_d;
            lo_carry <= lo_carry_d;
            a_hi     <= in_s[WIDTH-1:HALF];
            b_hi     <= b_in[WIDTH-1:HALF];
            c_msb    <= in_c[WIDTH-1];
         end
      end
   end

   // Stage 2: finish the high half and hold the result until downstream takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
      end else begin
         out_valid <= s1_adv | (out_valid & !out_ready);
         if (s1_adv) begin
            out_sum  <= {hi_sum, lo_sum};
            out_cout <= hi_cout | c_msb;
         end
      end
   end

endmodule

// File: tb/tb_wallace_cpa_pipe.sv
// tb_wallace_cpa_pipe: directed and random checks of the pipelined CPA stage
module tb_wallace_cpa_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_s = '0;
   logic [31:0] in_c = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_sum;
   logic        out_cout;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [31:0] s;
      logic [31:0] c;
      logic [31:0] sum;
      logic        cout;
   } vec_t;

   vec_t vt[8];
   logic [31:0] rs[100];
   logic [31:0] rc[100];

   wallace_cpa_pipe #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_s      (in_s),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [32:0] model(input logic [31:0] s, input logic [31:0] c);
      logic [33:0] t;
      t = {2'b0, s} + {1'b0, c, 1'b0};
      return {|t[33:32], t[31:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] s, input logic [31:0] c);
      in_valid = 1'b1;
      in_s     = s;
      in_c     = c;
   endtask

   initial begin
      logic [32:0] r1, r2, r3, m;
      vt[0] = '{32'h00000005, 32'h00000003, 32'h0000000B, 1'b0};
      vt[1] = '{32'h0000FFFF, 32'h00000001, 32'h00010001, 1'b0};
      vt[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1};
      vt[3] = '{32'h00000000, 32'h80000000, 32'h00000000, 1'b1};
      vt[4] = '{32'h12345678, 32'h11111111, 32'h3456789A, 1'b0};
      vt[5] = '{32'h80000000, 32'h40000000, 32'h00000000, 1'b1};
      vt[6] = '{32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0};
      vt[7] = '{32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b1};

      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_cout", out_cout, 0);
      step();
      step();
      #3 rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", in_ready, 1);

      // single transfers: latency and value per table entry
      for (int i = 0; i < 8; i++) begin
         drive(vt[i].s, vt[i].c);
         step();
         in_valid = 1'b0;
         chk($sformatf("v%0d_lat1", i), out_valid, 0);
         step();
         chk($sformatf("v%0d_valid", i), out_valid, 1);
         chk($sformatf("v%0d_sum", i), out_sum, vt[i].sum);
         chk($sformatf("v%0d_cout", i), out_cout, vt[i].cout);
      end
      step();
      chk("idle_valid", out_valid, 0);

      // backpressure: two results park, third waits
      r1 = model(32'h11111111, 32'h00000001);
      r2 = model(32'hFFFF0000, 32'h00008000);
      r3 = model(32'hA5A5A5A5, 32'h5A5A5A5A);
      out_ready = 1'b0;
      drive(32'h11111111, 32'h00000001);
      chk("bp_rdy1", in_ready, 1);
      step();
      drive(32'hFFFF0000, 32'h00008000);
      chk("bp_rdy2", in_ready, 1);
      step();
      drive(32'hA5A5A5A5, 32'h5A5A5A5A);
      chk("bp_rdy3", in_ready, 0);
      chk("bp_hold_sum", {out_cout, out_sum}, r1);
      step();
      step();
      chk("bp_stall_rdy", in_ready, 0);
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_sum", {out_cout, out_sum}, r1);
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("bp_out2_valid", out_valid, 1);
      chk("bp_out2", {out_cout, out_sum}, r2);
      step();
      chk("bp_out3_valid", out_valid, 1);
      chk("bp_out3", {out_cout, out_sum}, r3);
      step();
      chk("bp_drained", out_valid, 0);

      // throughput: 100 back-to-back random pairs
      for (int i = 0; i < 100; i++) begin
         rs[i] = $urandom;
         rc[i] = $urandom;
      end
      for (int t = 0; t < 102; t++) begin
         chk($sformatf("tp%0d_valid", t), out_valid, (t >= 2) ? 1 : 0);
         if (t >= 2) begin
            m = model(rs[t-2], rc[t-2]);
            chk($sformatf("tp%0d_res", t - 2), {out_cout, out_sum}, m);
         end
         if (t < 100) begin
            chk($sformatf("tp%0d_rdy", t), in_ready, 1);
            drive(rs[t], rc[t]);
         end else
            in_valid = 1'b0;
         step();
      end
      chk("tp_drained", out_valid, 0);

      // reset mid-flight discards both in-flight results
      drive(32'h00000100, 32'h00000100);
      step();
      drive(32'h00000200, 32'h00000200);
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mr_valid", out_valid, 0);
      chk("mr_sum", out_sum, 0);
      chk("mr_cout", out_cout, 0);
      chk("mr_rdy", in_ready, 0);
      step();
      #3 rst_n = 1'b1;
      step();
      drive(32'h00000007, 32'h00000009);
      step();
      in_valid = 1'b0;
      chk("mr_no_stale", out_valid, 0);
      step();
      chk("mr_first_valid", out_valid, 1);
      chk("mr_first_sum", {out_cout, out_sum}, 33'h00000019);
      step();
      chk("mr_end_idle", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
